// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier.
// Modes: unsigned a*b, signed a*b (sign-magnitude), and unsigned a*a.
// Each operation takes WIDTH iterations in RUN and then one DONE cycle.
// The result register keeps the last completed product until the next
// completion or until reset.

module shift_add_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    // ------------------------------------------------------------------
    // Local parameters and types
    // ------------------------------------------------------------------

    localparam int unsigned ProdW = 2 * WIDTH;
    // The counter has to hold the value WIDTH itself, so it needs one extra code.
    localparam int unsigned CntW  = $clog2(WIDTH + 1);

    localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(1);

    localparam logic [1:0] ModeUnsigned = 2'b00;
    localparam logic [1:0] ModeSigned   = 2'b01;
    localparam logic [1:0] ModeSquare   = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------

    state_e            state_q, state_d;
    logic [ProdW-1:0]  acc_q, acc_d;        // partial-product accumulator
    logic [ProdW-1:0]  mcand_q, mcand_d;    // multiplicand, shifts left
    logic [WIDTH-1:0]  mplier_q, mplier_d;  // multiplier, shifts right
    logic [CntW-1:0]   cnt_q, cnt_d;        // iterations still to run
    logic              neg_q, neg_d;        // product must be negated
    logic [ProdW-1:0]  result_q, result_d;

    // ------------------------------------------------------------------
    // Operand conditioning signals
    // ------------------------------------------------------------------

    logic              sign_a;
    logic              sign_b;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic              cap_neg;

    // ------------------------------------------------------------------
    // Iteration datapath signals
    // ------------------------------------------------------------------

    logic [ProdW-1:0]  addend;
    logic [ProdW-1:0]  acc_sum;
    logic [ProdW-1:0]  acc_final;
    logic              accept;
    logic              last_iter;

    // ------------------------------------------------------------------
    // Control strobes
    // ------------------------------------------------------------------

    // A start request is honoured only while idle; busy states ignore it.
    assign accept    = (state_q == StIdle) && start;
    assign last_iter = (state_q == StRun) && (cnt_q == CntLast);

    // Turn the raw operands into magnitudes plus a product sign, depending on mode.
    always_comb begin
        sign_a  = 1'b0;
        sign_b  = 1'b0;
        mag_a   = op_a;
        mag_b   = op_b;
        cap_neg = 1'b0;
        case (mode)
            ModeSigned: begin
                sign_a  = op_a[WIDTH-1];
                sign_b  = op_b[WIDTH-1];
                // The most-negative value negates to itself, and its bit pattern
                // read as unsigned is the magnitude 2^(WIDTH-1).
                mag_a   = sign_a ? -op_a : op_a;
                mag_b   = sign_b ? -op_b : op_b;
                cap_neg = sign_a ^ sign_b;
            end
            ModeSquare: begin
                mag_a = op_a;
                mag_b = op_a;
            end
            // Mode 00 and the reserved mode 11 both multiply unsigned.
            default: begin
                mag_a = op_a;
                mag_b = op_b;
            end
        endcase
    end

    // One shift-add step: add the multiplicand when the multiplier LSB is set.
    always_comb begin
        addend    = mplier_q[0] ? mcand_q : '0;
        acc_sum   = acc_q + addend;
        // Two's-complement negation wraps modulo 2^(2*WIDTH).
        acc_final = neg_q ? -acc_sum : acc_sum;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN always takes exactly WIDTH edges, and DONE always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode, driven from the state register only.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            StIdle: begin
                busy = 1'b0;
                done = 1'b0;
            end
            StRun: begin
                busy = 1'b1;
                done = 1'b0;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Datapath next-state: capture on accept, iterate in RUN, publish on the last step.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        if (accept) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            cnt_d    = CntInit;
            neg_d    = cap_neg;
        end else if (state_q == StRun) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CntLast;
            // result is loaded on the same edge that enters DONE.
            if (last_iter) begin
                result_d = acc_final;
            end
        end
    end

    // Datapath registers; reset clears every one of them, including while a run is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------

    // done is a single-cycle pulse.
    a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

    // DONE is always followed by IDLE.
    a_done_to_idle : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StDone) |=> (state_q == StIdle));

    // result is stable while an operation is running.
    a_result_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StRun && !last_iter) |=> $stable(result_q));

    // The counter never hits zero while in RUN.
    a_cnt_nonzero : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StRun) |-> (cnt_q != '0));

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult with WIDTH=8.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.

module tb_shift_add_mult;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [1:0]     mode;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [1:0]     mode;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[14];

    shift_add_mult #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run one operation. Operands and mode are scrambled while the run is in flight,
    // and the bench then checks latency, the busy window, result hold, and the product.
    task automatic run_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string name);
        int             done_at = -1;
        int             ndone   = 0;
        logic           busy_ok = 1'b1;
        logic           hold_ok = 1'b1;
        logic [2*W-1:0] prev;
        @(negedge clk);
        mode  = m;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        prev  = result;
        @(negedge clk);  // start was sampled at edge k
        start = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        for (int j = 1; j <= W + 1; j++) begin
            op_a = 8'($urandom);
            op_b = 8'($urandom);
            mode = 2'($urandom);
            @(negedge clk);  // after edge k+j
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = j;
            end
            if (busy !== (j <= W)) busy_ok = 1'b0;
            if (j < W && result !== prev) hold_ok = 1'b0;
        end
        check({name, " latency"}, done_at, W);
        check({name, " pulses"}, ndone, 1);
        check({name, " busy"}, busy_ok, 1);
        check({name, " hold"}, hold_ok, 1);
        check({name, " result"}, result, exp);
    endtask

    initial begin
        int             first_done;
        int             second_done;
        int             ndone;
        logic           ok;
        logic [2*W-1:0] r8;
        logic [2*W-1:0] r18;

        //         mode   a      b      expected
        vecs[0]  = '{2'b00, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1]  = '{2'b01, 8'hFD, 8'h05, 16'hFFF1};
        vecs[2]  = '{2'b01, 8'h80, 8'h80, 16'h4000};
        vecs[3]  = '{2'b01, 8'h80, 8'h7F, 16'hC080};
        vecs[4]  = '{2'b10, 8'hF0, 8'h12, 16'hE100};
        vecs[5]  = '{2'b11, 8'h0C, 8'h0A, 16'h0078};
        vecs[6]  = '{2'b00, 8'h00, 8'h5A, 16'h0000};
        vecs[7]  = '{2'b00, 8'h12, 8'h34, 16'h03A8};
        vecs[8]  = '{2'b01, 8'hFF, 8'hFF, 16'h0001};
        vecs[9]  = '{2'b01, 8'hFF, 8'h01, 16'hFFFF};
        vecs[10] = '{2'b01, 8'h00, 8'h80, 16'h0000};
        vecs[11] = '{2'b01, 8'h7F, 8'h7F, 16'h3F01};
        vecs[12] = '{2'b10, 8'hFF, 8'h00, 16'hFE01};
        vecs[13] = '{2'b01, 8'h06, 8'hFC, 16'hFFE8};

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Handshake: starts during RUN (edges 4, 8) and DONE (edge 9) are ignored,
        // and the start at edge 10 (IDLE after DONE) is accepted.
        first_done  = -1;
        second_done = -1;
        ndone       = 0;
        r8          = '0;
        r18         = '0;
        @(negedge clk);
        mode  = 2'b00;
        op_a  = 8'h0C;
        op_b  = 8'h0A;
        start = 1'b1;  // sampled at edge 0
        for (int j = 0; j <= 28; j++) begin
            @(negedge clk);  // after edge j
            if (done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = j;
                else if (second_done < 0) second_done = j;
            end
            if (j == 8)  r8  = result;
            if (j == 18) r18 = result;
            start = (j == 3 || j == 7 || j == 8 || j == 9);
            if (j == 9) begin
                mode = 2'b00;
                op_a = 8'h03;
                op_b = 8'h05;
            end else begin
                op_a = 8'($urandom);
                op_b = 8'($urandom);
                mode = 2'($urandom);
            end
        end
        start = 1'b0;
        check("hs first done edge", first_done, 8);
        check("hs second done edge", second_done, 18);
        check("hs done count", ndone, 2);
        check("hs first result", r8, 16'h0078);
        check("hs second result", r18, 16'h000F);

        // Result holds for 20 idle cycles.
        ok = 1'b1;
        for (int j = 0; j < 20; j++) begin
            op_a = 8'($urandom);
            op_b = 8'($urandom);
            @(negedge clk);
            if (result !== 16'h000F || done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        check("idle hold", ok, 1);

        // Reset after edge 4 of a run.
        @(negedge clk);
        mode  = 2'b00;
        op_a  = 8'hFF;
        op_b  = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);  // after edge 4
        check("pre-abort busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort result", result, 0);
        ok = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || result !== '0) ok = 1'b0;
        end
        check("abort quiet", ok, 1);
        rst_n = 1'b1;
        run_op(2'b01, 8'hFD, 8'h05, 16'hFFF1, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
